// File: rtl/bus_controller.sv
// 8288-style bus controller: decodes CPU status into T1..T4 bus cycles with ALE, data buffer and command strobes.
// Optional feature: define IO_WAIT_STATE_EN to insert one mandatory wait state in I/O and INTA cycles.
module bus_controller (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] cpu_status_n,
  input  logic       ready,
  input  logic       address_enable_n,
  output logic       address_latch_enable,
  output logic       data_enable,
  output logic       data_direction,
  output logic       io_read_command_n,
  output logic       io_write_command_n,
  output logic       advanced_io_write_command_n,
  output logic       memory_read_command_n,
  output logic       memory_write_command_n,
  output logic       advanced_memory_write_command_n,
  output logic       interrupt_acknowledge_n,
  output logic       bus_cycle_active
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_TW   = 3'd4,
    S_T4   = 3'd5
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_type;
  logic       r_prev_passive;

  logic w_passive;
  logic w_start;
  logic w_inta;
  logic w_ior;
  logic w_iow;
  logic w_mrd;
  logic w_mwr;
  logic w_read;
  logic w_write;
  logic w_force_tw;

  assign w_passive = (cpu_status_n == 3'b111);
  // A cycle starts only on a passive-to-active status transition.
  assign w_start   = !w_passive && r_prev_passive;

  assign w_inta  = (r_type == 3'b000);
  assign w_ior   = (r_type == 3'b001);
  assign w_iow   = (r_type == 3'b010);
  assign w_mrd   = (r_type == 3'b100) || (r_type == 3'b101);
  assign w_mwr   = (r_type == 3'b110);
  assign w_read  = w_inta || w_ior || w_mrd;
  assign w_write = w_iow || w_mwr;

`ifdef IO_WAIT_STATE_EN
  assign w_force_tw = w_inta || w_ior || w_iow;
`else
  assign w_force_tw = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_prev_passive <= 1'b1;
      r_type         <= 3'b111;
    end else begin
      r_state        <= w_next;
      r_prev_passive <= w_passive;
      if ((r_state == S_IDLE) && w_start) begin
        r_type <= cpu_status_n;
      end
    end
  end

  always_comb begin
    w_next                          = r_state;
    address_latch_enable            = 1'b0;
    data_enable                     = 1'b0;
    data_direction                  = 1'b0;
    bus_cycle_active                = 1'b0;
    io_read_command_n               = 1'b1;
    io_write_command_n              = 1'b1;
    advanced_io_write_command_n     = 1'b1;
    memory_read_command_n           = 1'b1;
    memory_write_command_n          = 1'b1;
    advanced_memory_write_command_n = 1'b1;
    interrupt_acknowledge_n         = 1'b1;

    case (r_state)
      S_IDLE: if (w_start) w_next = S_T1;
      S_T1:   w_next = S_T2;
      S_T2:   w_next = S_T3;
      S_T3:   w_next = (w_force_tw || !ready) ? S_TW : S_T4;
      S_TW:   if (ready) w_next = S_T4;
      S_T4:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase

    if (r_state != S_IDLE) begin
      bus_cycle_active = 1'b1;
      data_direction   = w_write;
    end

    if (r_state == S_T1) begin
      address_latch_enable = !address_enable_n;
      data_enable          = w_write;
    end

    if ((r_state == S_T2) || (r_state == S_T3) || (r_state == S_TW)) begin
      data_enable = w_read || w_write;
      // Commands are gated by bus ownership without disturbing sequencing.
      if (!address_enable_n) begin
        io_read_command_n               = !w_ior;
        memory_read_command_n           = !w_mrd;
        interrupt_acknowledge_n         = !w_inta;
        advanced_io_write_command_n     = !w_iow;
        advanced_memory_write_command_n = !w_mwr;
        if (r_state != S_T2) begin
          io_write_command_n     = !w_iow;
          memory_write_command_n = !w_mwr;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_controller.sv
// Directed table-driven bench for bus_controller plus hand sequences for async reset and bus ownership.
module tb_bus_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] cpu_status_n;
  logic       ready;
  logic       address_enable_n;
  logic       address_latch_enable, data_enable, data_direction, bus_cycle_active;
  logic       io_read_command_n, io_write_command_n, advanced_io_write_command_n;
  logic       memory_read_command_n, memory_write_command_n, advanced_memory_write_command_n;
  logic       interrupt_acknowledge_n;

  int checks = 0;
  int failures = 0;

  bus_controller dut (
    .clock                           (clock),
    .reset                           (reset),
    .cpu_status_n                    (cpu_status_n),
    .ready                           (ready),
    .address_enable_n                (address_enable_n),
    .address_latch_enable            (address_latch_enable),
    .data_enable                     (data_enable),
    .data_direction                  (data_direction),
    .io_read_command_n               (io_read_command_n),
    .io_write_command_n              (io_write_command_n),
    .advanced_io_write_command_n     (advanced_io_write_command_n),
    .memory_read_command_n           (memory_read_command_n),
    .memory_write_command_n          (memory_write_command_n),
    .advanced_memory_write_command_n (advanced_memory_write_command_n),
    .interrupt_acknowledge_n         (interrupt_acknowledge_n),
    .bus_cycle_active                (bus_cycle_active)
  );

  always #5 clock = ~clock;

  // {ale, den, dtr, bca, ior_n, iow_n, aiow_n, mrdc_n, mwtc_n, amwc_n, inta_n}
  logic [10:0] obs;
  assign obs = {address_latch_enable, data_enable, data_direction, bus_cycle_active,
                io_read_command_n, io_write_command_n, advanced_io_write_command_n,
                memory_read_command_n, memory_write_command_n,
                advanced_memory_write_command_n, interrupt_acknowledge_n};

  localparam logic [10:0] O_IDLE = 11'b0000_1111111;
  localparam logic [10:0] O_T1R  = 11'b1001_1111111;
  localparam logic [10:0] O_BCA  = 11'b0001_1111111;
  localparam logic [10:0] O_MRD  = 11'b0101_1110111;
  localparam logic [10:0] O_DENR = 11'b0101_1111111;
  localparam logic [10:0] O_T1W  = 11'b1111_1111111;
  localparam logic [10:0] O_T4W  = 11'b0011_1111111;
  localparam logic [10:0] O_AIOW = 11'b0111_1101111;
  localparam logic [10:0] O_IOW  = 11'b0111_1001111;
  localparam logic [10:0] O_AMW  = 11'b0111_1111101;
  localparam logic [10:0] O_MW   = 11'b0111_1111001;
  localparam logic [10:0] O_IOR  = 11'b0101_0111111;
  localparam logic [10:0] O_INTA = 11'b0101_1111110;

  typedef struct {
    logic [2:0]  st;
    logic        rdy;
    logic        aen;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [2:0] s, input logic r, input logic a, input logic [10:0] e);
    vec_t v;
    v.st = s; v.rdy = r; v.aen = a; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [10:0] e);
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL %s got=%b want=%b", nm, obs, e);
    end
  endtask

  task automatic step(input logic [2:0] s, input logic r, input logic a,
                      input logic [10:0] e, input string nm);
    cpu_status_n     = s;
    ready            = r;
    address_enable_n = a;
    @(posedge clock);
    #1;
    check(nm, e);
  endtask

  initial begin
    // memory read 101; status change after T1 ignored; held status does not restart
    add(3'b101, 1, 0, O_T1R);
    add(3'b101, 1, 0, O_MRD);
    add(3'b110, 1, 0, O_MRD);
    add(3'b101, 1, 0, O_BCA);
    add(3'b101, 1, 0, O_IDLE);
    add(3'b101, 1, 0, O_IDLE);
    add(3'b111, 1, 0, O_IDLE);
    // I/O write 010
    add(3'b010, 1, 0, O_T1W);
    add(3'b010, 1, 0, O_AIOW);
    add(3'b010, 1, 0, O_IOW);
`ifdef IO_WAIT_STATE_EN
    add(3'b111, 1, 0, O_IOW);
`endif
    add(3'b111, 1, 0, O_T4W);
    add(3'b111, 1, 0, O_IDLE);
    // memory write 110 with three wait states
    add(3'b110, 1, 0, O_T1W);
    add(3'b110, 1, 0, O_AMW);
    add(3'b110, 1, 0, O_MW);
    add(3'b110, 0, 0, O_MW);
    add(3'b110, 0, 0, O_MW);
    add(3'b110, 0, 0, O_MW);
    add(3'b110, 1, 0, O_T4W);
    add(3'b111, 1, 0, O_IDLE);
    // memory read with DMA owning the bus
    add(3'b101, 1, 1, O_BCA);
    add(3'b101, 1, 1, O_DENR);
    add(3'b101, 1, 1, O_DENR);
    add(3'b101, 1, 1, O_BCA);
    add(3'b111, 1, 1, O_IDLE);
    // halt 011
    add(3'b011, 1, 0, O_T1R);
    add(3'b011, 1, 0, O_BCA);
    add(3'b011, 1, 0, O_BCA);
    add(3'b111, 1, 0, O_BCA);
    add(3'b111, 1, 0, O_IDLE);
    // INTA 000
    add(3'b000, 1, 0, O_T1R);
    add(3'b000, 1, 0, O_INTA);
    add(3'b000, 1, 0, O_INTA);
`ifdef IO_WAIT_STATE_EN
    add(3'b111, 1, 0, O_INTA);
`endif
    add(3'b111, 1, 0, O_BCA);
    add(3'b111, 1, 0, O_IDLE);
    // I/O read 001
    add(3'b001, 1, 0, O_T1R);
    add(3'b001, 1, 0, O_IOR);
    add(3'b001, 1, 0, O_IOR);
`ifdef IO_WAIT_STATE_EN
    add(3'b111, 1, 0, O_IOR);
`endif
    add(3'b111, 1, 0, O_BCA);
    add(3'b111, 1, 0, O_IDLE);
    // code fetch 100 with one wait state
    add(3'b100, 1, 0, O_T1R);
    add(3'b100, 1, 0, O_MRD);
    add(3'b100, 1, 0, O_MRD);
    add(3'b100, 0, 0, O_MRD);
    add(3'b100, 1, 0, O_BCA);
    add(3'b111, 1, 0, O_IDLE);

    reset            = 1'b1;
    cpu_status_n     = 3'b111;
    ready            = 1'b1;
    address_enable_n = 1'b0;
    #1;
    check("reset_outputs", O_IDLE);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    step(3'b111, 1, 0, O_IDLE, "idle_after_reset");

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].st, vecs[i].rdy, vecs[i].aen, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // bus ownership gates commands combinationally mid-cycle
    step(3'b101, 1, 0, O_T1R, "aen_t1");
    step(3'b101, 1, 0, O_MRD, "aen_t2");
    address_enable_n = 1'b1;
    #1;
    check("aen_comb_off", O_DENR);
    address_enable_n = 1'b0;
    #1;
    check("aen_comb_on", O_MRD);
    step(3'b101, 1, 0, O_MRD, "aen_t3");
    step(3'b111, 1, 0, O_BCA, "aen_t4");
    step(3'b111, 1, 0, O_IDLE, "aen_idle");

    // async reset during TW of a memory write
    step(3'b110, 1, 0, O_T1W, "rst_t1");
    step(3'b110, 1, 0, O_AMW, "rst_t2");
    step(3'b110, 1, 0, O_MW, "rst_t3");
    step(3'b110, 0, 0, O_MW, "rst_tw");
    #2;
    reset        = 1'b1;
    cpu_status_n = 3'b111;
    #1;
    check("rst_async", O_IDLE);
    @(negedge clock);
    reset = 1'b0;
    step(3'b111, 1, 0, O_IDLE, "rst_idle");
    step(3'b101, 1, 0, O_T1R, "rst_restart");
    step(3'b101, 1, 0, O_MRD, "rst_restart_t2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_controller.md
BUS_CONTROLLER -- requirements
Module: bus_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named as follows: clock  input  1  system bus clock; reset  input  1  asynchronous active-high reset.
REQ-002 The block SHALL have these ports:
- cpu_status_n  input  3  CPU S2..S0 (111 = passive).
- ready  input  1  wait control; 0 extends the cycle.
- address_enable_n  input  1  1 = DMA owns bus; CPU commands and ALE suppressed.
- address_latch_enable  output  1  one-clock address latch pulse.
- data_enable  output  1  data buffer enable.
- data_direction  output  1  1 = CPU drives data (write), 0 = read.
- io_read_command_n, io_write_command_n, advanced_io_write_command_n  output  1 each  I/O strobes, active-low.
- memory_read_command_n, memory_write_command_n, advanced_memory_write_command_n  output  1 each  memory strobes, active-low.
- interrupt_acknowledge_n  output  1  INTA strobe, active-low.
- bus_cycle_active  output  1  high from T1 through T4.

Function
REQ-003 The status decode SHALL be: 000 INTA, 001 I/O read, 010 I/O write, 011 halt, 100 code fetch, 101 memory read, 110 memory write, 111 passive.
REQ-004 The state machine SHALL have the states IDLE, T1, T2, T3, TW and T4, all registered on the rising edge of clock.
REQ-005 IDLE SHALL go to T1 when status is non-passive and the previous sampled status was passive, and SHALL latch the decoded status at that edge.
REQ-006 Transitions SHALL be: T1->T2; T2->T3; T3->T4 if ready=1, else TW; TW->T4 when ready=1; T4->IDLE.
REQ-007 A status that stays non-passive through T4 SHALL NOT start a new cycle until passive has been sampled.
REQ-008 address_latch_enable SHALL be 1 only in T1, and only when address_enable_n=0; halt cycles SHALL produce ALE with no command.
REQ-009 Read commands (I/O read, memory read for code fetch/read, INTA) SHALL be asserted in T2, T3 and TW.
REQ-010 Advanced write commands SHALL be asserted in T2, T3 and TW; normal write commands SHALL be asserted in T3 and TW only.
REQ-011 All commands SHALL be deasserted in T4 and IDLE.
REQ-012 data_direction SHALL be 1 from T1 to T4 for write cycles and 0 otherwise.
REQ-013 data_enable SHALL be 1 in T2, T3 and TW for reads and INTA, and in T1 through TW for writes.
REQ-014 When address_enable_n=1, all command outputs SHALL be forced inactive combinationally while the state machine continues to sequence.
REQ-015 Status changes after T1 SHALL NOT alter the latched cycle type.
REQ-016 At most one command output SHALL be active at any time, counting each advanced/normal write pair as one.

Reset
REQ-017 On reset the block SHALL enter IDLE and take the passive status as the previous sample.
REQ-018 On reset all *_n outputs SHALL be 1, and address_latch_enable, data_enable, data_direction and bus_cycle_active SHALL be 0.
REQ-019 Reset asserted mid-cycle SHALL deassert every strobe asynchronously, without waiting for a clock edge.

Configuration
REQ-020 With IO_WAIT_STATE_EN defined, I/O read/write and INTA cycles SHALL spend exactly one TW before ready is considered, giving a minimum of 5 clocks.
REQ-021 Without IO_WAIT_STATE_EN, I/O cycles SHALL follow REQ-006 unchanged, giving a minimum of 4 clocks.
REQ-022 Memory, code fetch and halt timing SHALL be unaffected by IO_WAIT_STATE_EN.

Verification
REQ-023 Memory read 101, ready=1: ALE in clock 1, memory_read_command_n low in clocks 2-3, high in clock 4, data_direction=0.
REQ-024 I/O write 010, ready=1, macro off: advanced_io_write_command_n low in clocks 2-3, io_write_command_n low in clock 3 only, data_direction=1 in clocks 1-4.
REQ-025 Memory write 110 with ready=0 for 3 clocks from T3: 3 TW states; both write strobes held low until T4; total 7 clocks.
REQ-026 I/O read 001 with IO_WAIT_STATE_EN, ready=1: exactly one TW; io_read_command_n low for 3 clocks.
REQ-027 address_enable_n=1 during memory read 101: no ALE and all strobes high, while bus_cycle_active still pulses for 4 clocks.
REQ-028 reset asserted during TW of a memory write: all strobes high immediately; IDLE; no new cycle until status is 111 then non-passive.
